// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared width derivation and post-processing helpers for the MAC datapath
package mac_pkg;

    // Post-processing is done at a fixed wide width so one function serves every block.
    localparam int POST_W = 64;

    typedef struct packed {
        logic signed [POST_W-1:0] value;
        logic                     sat;
    } post_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int acc_width(input int weight_width, input int feature_width, input int max_len);
        return weight_width + feature_width + clog2(max_len);
    endfunction

    function automatic int len_width(input int max_len);
        return clog2(max_len + 1);
    endfunction

    function automatic int shift_width(input int acc_w);
        return clog2(acc_w);
    endfunction

    // Round-half-up right shift, optional ReLU, then saturation to a signed out_width range.
    function automatic post_t round_relu_sat(input logic signed [POST_W-1:0] acc,
                                             input int shift,
                                             input logic relu,
                                             input int out_width);
        logic signed [POST_W-1:0] r;
        logic signed [POST_W-1:0] hi;
        logic signed [POST_W-1:0] lo;
        post_t res;
        if (shift > 0) begin
            r = (acc + (64'sd1 <<< (shift - 1))) >>> shift;
        end else begin
            r = acc;
        end
        if (relu && (r < 0)) begin
            r = '0;
        end
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_width - 1));
        res.sat = 1'b0;
        if (r > hi) begin
            r = hi;
            res.sat = 1'b1;
        end else if (r < lo) begin
            r = lo;
            res.sat = 1'b1;
        end
        res.value = r;
        return res;
    endfunction

endpackage

// File: rtl/mac_array_stream_if.sv
// rtl/mac_array_stream_if.sv - input beat stream and output result stream of the MAC array
// master: beat producer / result consumer; slave: the MAC array
interface mac_array_stream_if #(
    parameter int WEIGHT_WIDTH  = 16,
    parameter int FEATURE_WIDTH = 16,
    parameter int LANES         = 4,
    parameter int OUT_WIDTH     = 16
);
    logic                            in_valid;
    logic                            in_ready;
    logic [LANES*WEIGHT_WIDTH-1:0]   in_weight;
    logic [FEATURE_WIDTH-1:0]        in_feature;
    logic                            out_valid;
    logic                            out_ready;
    logic [LANES*OUT_WIDTH-1:0]      out_data;
    logic [LANES-1:0]                out_sat;

    modport master (
        output in_valid, in_weight, in_feature, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  in_valid, in_weight, in_feature, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/mac_lane.sv
// rtl/mac_lane.sv - one MAC lane: operand register, multiplier, accumulator, round/ReLU/saturate
// Ports: clk, reset_n, clear; load (capture operands), step (accumulate stage-1 beat),
// first (restart accumulation), weight/feature operands, shift/relu for the result,
// res_data/res_sat combinational post-processed accumulator value.
module mac_lane
    import mac_pkg::*;
#(
    parameter int WEIGHT_WIDTH  = 16,
    parameter int FEATURE_WIDTH = 16,
    parameter int ACC_WIDTH     = 38,
    parameter int SW            = 6,
    parameter int OUT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     clear,
    input  logic                     load,
    input  logic                     step,
    input  logic                     first,
    input  logic [WEIGHT_WIDTH-1:0]  weight,
    input  logic [FEATURE_WIDTH-1:0] feature,
    input  logic [SW-1:0]            shift,
    input  logic                     relu,
    output logic [OUT_WIDTH-1:0]     res_data,
    output logic                     res_sat
);
    localparam int PW = WEIGHT_WIDTH + FEATURE_WIDTH;

    logic [WEIGHT_WIDTH-1:0]  w_q;
    logic [FEATURE_WIDTH-1:0] f_q;
    logic signed [PW-1:0]     prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc;
    post_t                    post;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_q <= '0;
            f_q <= '0;
        end else if (load) begin
            w_q <= weight;
            f_q <= feature;
        end
    end

    // Operands are sign-extended to the full product width so the low PW bits are exact.
    assign prod = $signed({{FEATURE_WIDTH{w_q[WEIGHT_WIDTH-1]}}, w_q})
                * $signed({{WEIGHT_WIDTH{f_q[FEATURE_WIDTH-1]}}, f_q});
    assign prod_ext = $signed({{(ACC_WIDTH-PW){prod[PW-1]}}, prod});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (step) begin
            acc <= (first ? {ACC_WIDTH{1'b0}} : acc) + prod_ext;
        end
    end

    assign post = round_relu_sat({{(POST_W-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc},
                                 int'(shift), relu, OUT_WIDTH);
    assign res_data = OUT_WIDTH'(post.value);
    assign res_sat  = post.sat;
endmodule

// File: rtl/mac_array_stream.sv
// rtl/mac_array_stream.sv - multi-lane streamed dot-product engine with round/ReLU/saturate output
// Ports: clk, reset_n (async active-low), clear (sync flush), cfg_len/cfg_shift/cfg_relu
// (sampled on a vector's first beat), io (beat and result streams), busy.
module mac_array_stream
    import mac_pkg::*;
#(
    parameter int WEIGHT_WIDTH  = 16,
    parameter int FEATURE_WIDTH = 16,
    parameter int LANES         = 4,
    parameter int MAX_LEN       = 64,
    parameter int OUT_WIDTH     = 16,
    localparam int ACC_WIDTH    = acc_width(WEIGHT_WIDTH, FEATURE_WIDTH, MAX_LEN),
    localparam int LW           = len_width(MAX_LEN),
    localparam int SW           = shift_width(ACC_WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    clear,
    input  logic [LW-1:0]           cfg_len,
    input  logic [SW-1:0]           cfg_shift,
    input  logic                    cfg_relu,
    mac_array_stream_if.slave       io,
    output logic                    busy
);
    logic          en;
    logic          fire;
    logic          first;
    logic          last;
    logic [LW-1:0] cnt;
    logic [LW-1:0] len_eff;
    logic [LW-1:0] len_q;
    logic [LW-1:0] cur_len;
    logic [SW-1:0] shift_q;
    logic [SW-1:0] cur_shift;
    logic          relu_q;
    logic          cur_relu;

    logic          s1_valid, s1_first, s1_last, s1_relu;
    logic [SW-1:0] s1_shift;
    logic          s2_valid, s2_last, s2_relu;
    logic [SW-1:0] s2_shift;

    logic                       out_valid_q;
    logic                       out_load;
    logic [LANES*OUT_WIDTH-1:0] out_data_q;
    logic [LANES*OUT_WIDTH-1:0] res_data;
    logic [LANES-1:0]           out_sat_q;
    logic [LANES-1:0]           res_sat;

    // One global enable: any held result that is not being taken freezes the whole pipe.
    assign en   = !out_valid_q || io.out_ready;
    assign fire = io.in_valid && en && !clear;

    always_comb begin
        len_eff = cfg_len;
        if (cfg_len == '0) begin
            len_eff = LW'(1);
        end else if (cfg_len > LW'(MAX_LEN)) begin
            len_eff = LW'(MAX_LEN);
        end
    end

    // On the first beat the live config applies; afterwards the latched copy does.
    assign first     = (cnt == '0);
    assign cur_len   = first ? len_eff   : len_q;
    assign cur_shift = first ? cfg_shift : shift_q;
    assign cur_relu  = first ? cfg_relu  : relu_q;
    assign last      = (cnt == cur_len - LW'(1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt     <= '0;
            len_q   <= LW'(1);
            shift_q <= '0;
            relu_q  <= 1'b0;
        end else if (clear) begin
            cnt <= '0;
        end else if (fire) begin
            cnt <= last ? '0 : cnt + LW'(1);
            if (first) begin
                len_q   <= len_eff;
                shift_q <= cfg_shift;
                relu_q  <= cfg_relu;
            end
        end
    end

    // Shift/ReLU travel with each beat so a following vector can reconfigure without a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_shift <= '0;
            s1_relu  <= 1'b0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
            s2_shift <= '0;
            s2_relu  <= 1'b0;
        end else if (clear) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (en) begin
            s1_valid <= fire;
            s1_first <= first;
            s1_last  <= last;
            s1_shift <= cur_shift;
            s1_relu  <= cur_relu;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
            s2_shift <= s1_shift;
            s2_relu  <= s1_relu;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        mac_lane #(
            .WEIGHT_WIDTH  (WEIGHT_WIDTH),
            .FEATURE_WIDTH (FEATURE_WIDTH),
            .ACC_WIDTH     (ACC_WIDTH),
            .SW            (SW),
            .OUT_WIDTH     (OUT_WIDTH)
        ) u_lane (
            .clk      (clk),
            .reset_n  (reset_n),
            .clear    (clear),
            .load     (fire),
            .step     (en && s1_valid),
            .first    (s1_first),
            .weight   (io.in_weight[i*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .feature  (io.in_feature),
            .shift    (s2_shift),
            .relu     (s2_relu),
            .res_data (res_data[i*OUT_WIDTH +: OUT_WIDTH]),
            .res_sat  (res_sat[i])
        );
    end

    // The accumulator is complete while stage 2 holds the last-tagged beat.
    assign out_load = en && s2_valid && s2_last;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
        end else if (clear) begin
            out_valid_q <= 1'b0;
        end else if (out_load) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res_data;
            out_sat_q   <= res_sat;
        end else if (io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign io.in_ready  = en;
    assign io.out_valid = out_valid_q;
    assign io.out_data  = out_data_q;
    assign io.out_sat   = out_sat_q;

    assign busy = (cnt != '0) || s1_valid || (s2_valid && s2_last) || out_valid_q;
endmodule

// File: tb/tb_mac_array_stream.sv
// tb/tb_mac_array_stream.sv - directed self-checking bench for mac_array_stream
module tb_mac_array_stream;
    import mac_pkg::*;

    localparam int LANES   = 4;
    localparam int WW      = 16;
    localparam int FW      = 16;
    localparam int OW      = 16;
    localparam int MAX_LEN = 64;
    localparam int ACC_W   = acc_width(WW, FW, MAX_LEN);
    localparam int LW      = len_width(MAX_LEN);
    localparam int SW      = shift_width(ACC_W);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          clear;
    logic [LW-1:0] cfg_len;
    logic [SW-1:0] cfg_shift;
    logic          cfg_relu;
    logic          busy;

    mac_array_stream_if #(.WEIGHT_WIDTH(WW), .FEATURE_WIDTH(FW), .LANES(LANES), .OUT_WIDTH(OW)) io ();

    mac_array_stream #(
        .WEIGHT_WIDTH (WW),
        .FEATURE_WIDTH(FW),
        .LANES        (LANES),
        .MAX_LEN      (MAX_LEN),
        .OUT_WIDTH    (OW)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear    (clear),
        .cfg_len  (cfg_len),
        .cfg_shift(cfg_shift),
        .cfg_relu (cfg_relu),
        .io       (io),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [LANES*OW-1:0] q_data[$];
    logic [LANES-1:0]    q_sat[$];

    always @(negedge clk) begin
        if (reset_n === 1'b1 && io.out_valid === 1'b1 && io.out_ready === 1'b1) begin
            q_data.push_back(io.out_data);
            q_sat.push_back(io.out_sat);
        end
    end

    function automatic logic [LANES*WW-1:0] pack_w(input int w0, input int w1, input int w2, input int w3);
        return {WW'(w3), WW'(w2), WW'(w1), WW'(w0)};
    endfunction

    function automatic int lane_of(input logic [LANES*OW-1:0] d, input int i);
        logic signed [OW-1:0] v;
        v = d[i*OW +: OW];
        return int'(v);
    endfunction

    task automatic send_beat(input logic [LANES*WW-1:0] w, input int f);
        int  n;
        logic r;
        n = 0;
        io.in_valid   = 1'b1;
        io.in_weight  = w;
        io.in_feature = FW'(f);
        r = 1'b0;
        while (!r && n < 100) begin
            @(negedge clk); #1;
            r = io.in_ready;
            @(posedge clk); #1;
            n++;
        end
        io.in_valid = 1'b0;
        if (!r) begin
            checks++;
            failures++;
            $display("FAIL beat_accept in_ready never high within %0d cycles", n);
        end
    endtask

    task automatic wait_q(input int n);
        int k;
        k = 0;
        while (q_data.size() < n && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b1; clear = 1'b0;
        cfg_len = LW'(1); cfg_shift = '0; cfg_relu = 1'b0;
        io.in_valid = 1'b0; io.in_weight = '0; io.in_feature = '0; io.out_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", io.out_valid); end
        checks++; if (io.out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h exp=0", io.out_data); end
        checks++; if (io.out_sat !== '0) begin failures++; $display("FAIL reset_out_sat got=%b exp=0", io.out_sat); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        checks++; if (io.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", io.in_ready); end
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic_latency();
        int exp_v[4] = '{32, 6, -14, 100};
        cfg_len = LW'(3); cfg_shift = '0; cfg_relu = 1'b0;
        send_beat(pack_w(4, 1, -1, 100), 1);
        send_beat(pack_w(5, 1, -2, 0), 2);
        send_beat(pack_w(6, 1, -3, 0), 3);
        checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL lat_t1 out_valid got=%0b exp=0", io.out_valid); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL lat_busy got=%0b exp=1", busy); end
        @(posedge clk); #1;
        checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL lat_t2 out_valid got=%0b exp=0", io.out_valid); end
        @(posedge clk); #1;
        checks++; if (io.out_valid !== 1'b1) begin failures++; $display("FAIL lat_t3 out_valid got=%0b exp=1", io.out_valid); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (lane_of(io.out_data, i) !== exp_v[i]) begin
                failures++; $display("FAIL basic_lane%0d got=%0d exp=%0d", i, lane_of(io.out_data, i), exp_v[i]);
            end
        end
        checks++; if (io.out_sat !== 4'b0000) begin failures++; $display("FAIL basic_sat got=%b exp=0000", io.out_sat); end
        @(posedge clk); #1;
        checks++; if (io.out_valid !== 1'b0) begin failures++; $display("FAIL basic_consumed out_valid got=%0b exp=0", io.out_valid); end
        wait_q(1);
        q_data.delete(); q_sat.delete();
    endtask

    task automatic test_round_relu();
        int exp_r[3][4] = '{'{-3, 3, -4, 4}, '{0, 3, 0, 4}, '{2, 1, -1, -2}};
        cfg_len = LW'(1); cfg_shift = SW'(1); cfg_relu = 1'b0;
        send_beat(pack_w(-7, 5, -8, 7), 1);
        cfg_relu = 1'b1;
        send_beat(pack_w(-7, 5, -8, 7), 1);
        cfg_shift = SW'(4); cfg_relu = 1'b0;
        send_beat(pack_w(24, 23, -24, -25), 1);
        wait_q(3);
        checks++; if (q_data.size() != 3) begin failures++; $display("FAIL round_count got=%0d exp=3", q_data.size()); end
        for (int v = 0; v < 3; v++) begin
            if (v < q_data.size()) begin
                for (int i = 0; i < 4; i++) begin
                    checks++;
                    if (lane_of(q_data[v], i) !== exp_r[v][i]) begin
                        failures++; $display("FAIL round_v%0d_lane%0d got=%0d exp=%0d", v, i, lane_of(q_data[v], i), exp_r[v][i]);
                    end
                end
            end
        end
        q_data.delete(); q_sat.delete();
    endtask

    task automatic test_saturation();
        int exp_v[4] = '{32767, -32768, 32767, 32767};
        cfg_len = LW'(2); cfg_shift = '0; cfg_relu = 1'b0;
        send_beat(pack_w(32767, -32767, 1, 1), 32767);
        send_beat(pack_w(32767, -32767, 1, 0), 32767);
        wait_q(1);
        checks++; if (q_data.size() != 1) begin failures++; $display("FAIL sat_count got=%0d exp=1", q_data.size()); end
        if (q_data.size() > 0) begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (lane_of(q_data[0], i) !== exp_v[i]) begin
                    failures++; $display("FAIL sat_lane%0d got=%0d exp=%0d", i, lane_of(q_data[0], i), exp_v[i]);
                end
            end
            checks++; if (q_sat[0] !== 4'b0111) begin failures++; $display("FAIL sat_flags got=%b exp=0111", q_sat[0]); end
        end
        q_data.delete(); q_sat.delete();
    endtask

    task automatic test_back_to_back();
        cfg_len = LW'(1); cfg_shift = '0; cfg_relu = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) send_beat(pack_w(k + 1, k + 17, -(k + 1), 100 * (k + 1)), 1);
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    io.out_ready = !(k >= 4 && k <= 9);
                    #1;
                    if (k >= 4 && k <= 9) begin
                        checks++;
                        if (io.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready_c%0d got=%0b exp=0", k, io.in_ready); end
                    end
                end
                io.out_ready = 1'b1;
            end
        join
        wait_q(6);
        checks++; if (q_data.size() != 6) begin failures++; $display("FAIL bp_count got=%0d exp=6", q_data.size()); end
        for (int k = 0; k < 6; k++) begin
            if (k < q_data.size()) begin
                checks++;
                if (lane_of(q_data[k], 0) !== k + 1) begin failures++; $display("FAIL bp_r%0d_lane0 got=%0d exp=%0d", k, lane_of(q_data[k], 0), k + 1); end
                checks++;
                if (lane_of(q_data[k], 2) !== -(k + 1)) begin failures++; $display("FAIL bp_r%0d_lane2 got=%0d exp=%0d", k, lane_of(q_data[k], 2), -(k + 1)); end
                checks++;
                if (lane_of(q_data[k], 3) !== 100 * (k + 1)) begin failures++; $display("FAIL bp_r%0d_lane3 got=%0d exp=%0d", k, lane_of(q_data[k], 3), 100 * (k + 1)); end
            end
        end
        q_data.delete(); q_sat.delete();
    endtask

    task automatic test_len_config();
        int exp_v[4] = '{3, 4, 5, 10};
        cfg_shift = '0; cfg_relu = 1'b0;
        cfg_len = LW'(0);
        send_beat(pack_w(3, 0, 0, 0), 1);
        send_beat(pack_w(4, 0, 0, 0), 1);
        cfg_len = LW'(2);
        send_beat(pack_w(2, 0, 0, 0), 1);
        cfg_len = LW'(1); cfg_shift = SW'(3);
        send_beat(pack_w(3, 0, 0, 0), 1);
        send_beat(pack_w(80, 0, 0, 0), 1);
        wait_q(4);
        checks++; if (q_data.size() != 4) begin failures++; $display("FAIL len_count got=%0d exp=4", q_data.size()); end
        for (int v = 0; v < 4; v++) begin
            if (v < q_data.size()) begin
                checks++;
                if (lane_of(q_data[v], 0) !== exp_v[v]) begin failures++; $display("FAIL len_r%0d got=%0d exp=%0d", v, lane_of(q_data[v], 0), exp_v[v]); end
            end
        end
        q_data.delete(); q_sat.delete();
        cfg_len = LW'(100); cfg_shift = '0;
        for (int k = 0; k < 64; k++) send_beat(pack_w(1, 2, 0, 0), 1);
        wait_q(1);
        checks++; if (q_data.size() != 1) begin failures++; $display("FAIL clamp_count got=%0d exp=1", q_data.size()); end
        if (q_data.size() > 0) begin
            checks++;
            if (lane_of(q_data[0], 0) !== 64) begin failures++; $display("FAIL clamp_lane0 got=%0d exp=64", lane_of(q_data[0], 0)); end
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clamp_busy got=%0b exp=0", busy); end
        q_data.delete(); q_sat.delete();
    endtask

    task automatic test_clear_reset_mid();
        for (int pass = 0; pass < 2; pass++) begin
            cfg_len = LW'(3); cfg_shift = '0; cfg_relu = 1'b0;
            send_beat(pack_w(50, 50, 0, 0), 1);
            send_beat(pack_w(50, 50, 0, 0), 1);
            if (pass == 0) begin
                clear = 1'b1;
                io.in_valid = 1'b1; io.in_weight = pack_w(50, 50, 0, 0); io.in_feature = FW'(1);
                @(posedge clk); #1;
                clear = 1'b0; io.in_valid = 1'b0;
            end else begin
                reset_n = 1'b0;
                #1;
                @(negedge clk) reset_n = 1'b1;
                @(posedge clk); #1;
            end
            checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush%0d_busy got=%0b exp=0", pass, busy); end
            cfg_len = LW'(2);
            send_beat(pack_w(1, 2, 0, 0), 2);
            send_beat(pack_w(1, 2, 0, 0), 3);
            wait_q(1);
            checks++; if (q_data.size() != 1) begin failures++; $display("FAIL flush%0d_count got=%0d exp=1", pass, q_data.size()); end
            if (q_data.size() > 0) begin
                checks++;
                if (lane_of(q_data[0], 0) !== 5) begin failures++; $display("FAIL flush%0d_lane0 got=%0d exp=5", pass, lane_of(q_data[0], 0)); end
                checks++;
                if (lane_of(q_data[0], 1) !== 10) begin failures++; $display("FAIL flush%0d_lane1 got=%0d exp=10", pass, lane_of(q_data[0], 1)); end
            end
            q_data.delete(); q_sat.delete();
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_basic_latency();
        test_round_relu();
        test_saturation();
        test_back_to_back();
        test_len_config();
        test_clear_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
